// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/writeback
// for lw, sw, R-type, I-type ALU, beq and jal.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       irwrite;
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctrl_t;

  state_t state_q;
  state_t state_n;
  ctrl_t  ctrl_q;

  function automatic state_t next_state_f(input state_t s, input logic [6:0] opc);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = DECODE;
      DECODE: begin
        case (opc)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTER;
          OP_ITYPE:     n = EXECUTEI;
          OP_BEQ:       n = BEQ;
          OP_JAL:       n = JAL;
          default:      n = FETCH;
        endcase
      end
      MEMADR:   n = (opc == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = MEMWB;
      EXECUTER: n = ALUWB;
      EXECUTEI: n = ALUWB;
      JAL:      n = ALUWB;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  // Control word belonging to a state; registered alongside the state so
  // every output below is a clean flop (apart from the reset/Zero gating).
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.pcupdate  = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      MEMREAD: begin
        c.adrsrc = 1'b1;
      end
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
      end
      JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_n = next_state_f(state_q, op);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH);
    end else begin
      state_q <= state_n;
      ctrl_q  <= ctrl_for(state_n);
    end
  end

  // ALU decoder: subtract only for R-type with funct7b5 set (I-type addi ignores it).
  always_comb begin
    ALUControl = 3'b000;
    case (ctrl_q.aluop)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are masked by reset directly so nothing is written while it is held.
  assign IRWrite   = ctrl_q.irwrite  & ~reset;
  assign PCWrite   = (ctrl_q.pcupdate | (ctrl_q.branch & Zero)) & ~reset;
  assign RegWrite  = ctrl_q.regwrite & ~reset;
  assign MemWrite  = ctrl_q.memwrite & ~reset;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ResultSrc = ctrl_q.resultsrc;
  assign state     = state_q;

endmodule
